// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
//   Turns hazard requests into per-stage write-enable, flush and bubble controls
//   for a 5-stage pipeline. A load-use stall holds PC and IF/ID while a bubble
//   enters ID/EX. A taken branch/jump squashes IF/ID and ID/EX. A busy data
//   memory freezes every stage. A flush that arrives while memory is busy is
//   remembered and applied in the cycle the wait ends. A wait that lasts
//   MAX_WAIT consecutive cycles locks the block into a sticky error state,
//   which only rst clears. Two saturating counters record stall/freeze cycles
//   and applied flushes.
//
// Parameters
//   MAX_WAIT      consecutive mem_busy cycles that trigger the timeout (0 = never)
//   CNT_W         width of the performance counters
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous reset, active-high
//   stall_req     in   load-use stall request from hazard detection
//   flush_req     in   branch/jump taken, squash IF/ID and ID/EX this cycle
//   mem_busy      in   data memory cannot complete the access this cycle
//   pc_we         out  PC register write enable
//   if_id_we      out  IF/ID register write enable
//   if_id_flush   out  IF/ID loads a NOP
//   id_ex_we      out  ID/EX register write enable
//   id_ex_bubble  out  ID/EX loads zeroed control
//   err_timeout   out  sticky memory-wait timeout flag
//   stall_cycles  out  saturating count of stall/freeze cycles
//   flush_count   out  saturating count of applied flushes
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl #(
   parameter int MAX_WAIT = 16,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_req,
   input  logic             flush_req,
   input  logic             mem_busy,
   output logic             pc_we,
   output logic             if_id_we,
   output logic             if_id_flush,
   output logic             id_ex_we,
   output logic             id_ex_bubble,
   output logic             err_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_WAIT  = 2'd1,
      S_ERROR = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              pend_flush_q, pend_flush_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

   logic              flush_eff;
   logic [WAIT_W-1:0] wait_inc;
   logic              stall_inc;
   logic              flush_inc;

   // Increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
      if (en && (v != {CNT_W{1'b1}}))
         return v + CNT_W'(1);
      return v;
   endfunction

   assign flush_eff = flush_req | pend_flush_q;
   assign wait_inc  = wait_cnt_q + WAIT_W'(1);

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      pend_flush_d = pend_flush_q;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_we     = 1'b0;
      id_ex_bubble = 1'b0;

      unique case (state_q)
         S_RUN, S_WAIT: begin
            if (mem_busy) begin
               // Full freeze; all enables stay at their 0 defaults. A flush
               // seen now is parked until memory releases the pipeline.
               stall_inc    = 1'b1;
               pend_flush_d = flush_eff;
               state_d      = S_WAIT;
               if (state_q == S_RUN) begin
                  wait_cnt_d = WAIT_W'(1);
                  if (MAX_WAIT == 1)
                     state_d = S_ERROR;
               end else begin
                  wait_cnt_d = wait_inc;
                  if ((MAX_WAIT != 0) && (wait_inc == WAIT_MAX))
                     state_d = S_ERROR;
               end
            end else begin
               // Not busy: the same rules apply whether we were running or
               // just leaving a wait, so a held flush or a stall acts at once.
               wait_cnt_d = '0;
               state_d    = S_RUN;
               if (flush_eff) begin
                  // Flush beats a concurrent load-use stall: the stalled
                  // instruction is squashed anyway.
                  pc_we        = 1'b1;
                  if_id_we     = 1'b1;
                  id_ex_we     = 1'b1;
                  if_id_flush  = 1'b1;
                  id_ex_bubble = 1'b1;
                  flush_inc    = 1'b1;
                  pend_flush_d = 1'b0;
               end else if (stall_req) begin
                  id_ex_we     = 1'b1;
                  id_ex_bubble = 1'b1;
                  stall_inc    = 1'b1;
               end else begin
                  pc_we        = 1'b1;
                  if_id_we     = 1'b1;
                  id_ex_we     = 1'b1;
               end
            end
         end
         S_ERROR: begin
            // Permanent freeze; counters and pending flush hold.
         end
         default: begin
            state_d = S_RUN;
         end
      endcase

      // Reset state is RUN, whose idle outputs would enable writes; force
      // everything quiet while rst is held.
      if (rst) begin
         pc_we        = 1'b0;
         if_id_we     = 1'b0;
         if_id_flush  = 1'b0;
         id_ex_we     = 1'b0;
         id_ex_bubble = 1'b0;
      end
   end

   assign err_d       = (state_d == S_ERROR);
   assign stall_cnt_d = sat_inc(stall_cnt_q, stall_inc);
   assign flush_cnt_d = sat_inc(flush_cnt_q, flush_inc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_RUN;
         wait_cnt_q   <= '0;
         pend_flush_q <= 1'b0;
         err_q        <= 1'b0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         pend_flush_q <= pend_flush_d;
         err_q        <= err_d;
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
      end
   end

   assign err_timeout  = err_q;
   assign stall_cycles = stall_cnt_q;
   assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
//   Two instances share one set of inputs: dut_a (MAX_WAIT=4, CNT_W=16) and
//   dut_b (MAX_WAIT=0, CNT_W=2). Inputs change on the falling edge; outputs are
//   sampled 1 time unit later, so each check sees the combinational controls
//   for the inputs of that cycle and the registered values from the last edge.
// -----------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, stall, flush, busy;

   logic        a_pc, a_ifid, a_iff, a_idex, a_bub, a_err;
   logic [15:0] a_sc, a_fc;
   logic        b_pc, b_ifid, b_iff, b_idex, b_bub, b_err;
   logic [1:0]  b_sc, b_fc;

   wire [5:0] a_ctl = {a_pc, a_ifid, a_iff, a_idex, a_bub, a_err};
   wire [5:0] b_ctl = {b_pc, b_ifid, b_iff, b_idex, b_bub, b_err};

   pipeline_stall_ctrl #(.MAX_WAIT(4), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .stall_req(stall), .flush_req(flush), .mem_busy(busy),
      .pc_we(a_pc), .if_id_we(a_ifid), .if_id_flush(a_iff), .id_ex_we(a_idex),
      .id_ex_bubble(a_bub), .err_timeout(a_err),
      .stall_cycles(a_sc), .flush_count(a_fc)
   );

   pipeline_stall_ctrl #(.MAX_WAIT(0), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .stall_req(stall), .flush_req(flush), .mem_busy(busy),
      .pc_we(b_pc), .if_id_we(b_ifid), .if_id_flush(b_iff), .id_ex_we(b_idex),
      .id_ex_bubble(b_bub), .err_timeout(b_err),
      .stall_cycles(b_sc), .flush_count(b_fc)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Per instance: is a memory wait in progress, is a flush parked, how long
   // the current wait has lasted, has it timed out, and the two counters.
   int MW[2]   = '{4, 0};
   int CMAX[2] = '{65535, 3};
   int m_wait[2], m_pend[2], m_wlen[2], m_err[2], m_sc[2], m_fc[2];

   function automatic void m_reset();
      for (int k = 0; k < 2; k++) begin
         m_wait[k] = 0; m_pend[k] = 0; m_wlen[k] = 0;
         m_err[k]  = 0; m_sc[k]   = 0; m_fc[k]   = 0;
      end
   endfunction

   function automatic int sat(input int v, input int mx);
      return (v + 1 > mx) ? mx : v + 1;
   endfunction

   // Advance the model by one clock edge using the inputs held across it.
   function automatic void m_step();
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_wait[k] = 0; m_pend[k] = 0; m_wlen[k] = 0;
            m_err[k]  = 0; m_sc[k]   = 0; m_fc[k]   = 0;
         end else if (m_err[k] != 0) begin
            // locked
         end else if (busy) begin
            m_sc[k]   = sat(m_sc[k], CMAX[k]);
            m_pend[k] = (m_pend[k] != 0 || flush) ? 1 : 0;
            m_wlen[k] = (m_wait[k] != 0) ? m_wlen[k] + 1 : 1;
            m_wait[k] = 1;
            if (MW[k] != 0 && m_wlen[k] >= MW[k]) m_err[k] = 1;
         end else begin
            m_wait[k] = 0;
            m_wlen[k] = 0;
            if (flush || m_pend[k] != 0) begin
               m_fc[k]   = sat(m_fc[k], CMAX[k]);
               m_pend[k] = 0;
            end else if (stall) begin
               m_sc[k] = sat(m_sc[k], CMAX[k]);
            end
         end
      end
   endfunction

   // Expected {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, err_timeout}.
   function automatic logic [5:0] m_ctl(input int k);
      if (rst)                      return 6'b000000;
      if (m_err[k] != 0)            return 6'b000001;
      if (busy)                     return 6'b000000;
      if (flush || m_pend[k] != 0)  return 6'b111110;
      if (stall)                    return 6'b000110;
      return 6'b110100;
   endfunction

   // One cycle: let the edge happen, then present new inputs mid-cycle.
   task automatic cyc(input logic r, input logic s, input logic f, input logic b);
      @(posedge clk);
      m_step();
      @(negedge clk);
      rst = r; stall = s; flush = f; busy = b;
      #1;
      if (r) m_reset();
   endtask

   // ---------------- directed vector table (dut_a) ----------------
   typedef struct {
      logic       r, s, f, b;
      logic [5:0] ctl;
      int         sc, fc;
   } vec_t;

   localparam int NV = 18;
   vec_t tbl[NV];

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; busy = 1'b0;
      m_reset();

      //           r  s  f  b   ctl        sc fc
      tbl[0]  = '{1, 0, 0, 0, 6'b000000, 0, 0}; // in reset: everything off
      tbl[1]  = '{0, 0, 0, 0, 6'b110100, 0, 0}; // idle run
      tbl[2]  = '{0, 1, 0, 0, 6'b000110, 0, 0}; // load-use stall
      tbl[3]  = '{0, 0, 0, 0, 6'b110100, 1, 0}; // released, one stall counted
      tbl[4]  = '{0, 1, 1, 0, 6'b111110, 1, 0}; // flush beats stall
      tbl[5]  = '{0, 0, 0, 0, 6'b110100, 1, 1}; // flush counted, stall not
      tbl[6]  = '{0, 0, 0, 1, 6'b000000, 1, 1}; // wait cycle 1
      tbl[7]  = '{0, 0, 1, 1, 6'b000000, 2, 1}; // wait cycle 2, flush parked
      tbl[8]  = '{0, 0, 0, 1, 6'b000000, 3, 1}; // wait cycle 3
      tbl[9]  = '{0, 0, 0, 0, 6'b111110, 4, 1}; // wait ends: parked flush applied
      tbl[10] = '{0, 0, 0, 0, 6'b110100, 4, 2};
      tbl[11] = '{0, 1, 0, 1, 6'b000000, 4, 2}; // busy outranks stall
      tbl[12] = '{0, 1, 0, 0, 6'b000110, 5, 2}; // stall re-evaluated at wait end
      tbl[13] = '{0, 0, 0, 0, 6'b110100, 6, 2};
      tbl[14] = '{1, 0, 0, 1, 6'b000000, 0, 0}; // async reset clears counters
      tbl[15] = '{0, 0, 1, 1, 6'b000000, 0, 0}; // wait starts with flush parked
      tbl[16] = '{1, 0, 0, 0, 6'b000000, 0, 0}; // reset mid-wait
      tbl[17] = '{0, 0, 0, 0, 6'b110100, 0, 0}; // parked flush discarded

      for (int i = 0; i < NV; i++) begin
         cyc(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].b);
         chk($sformatf("tbl%0d_ctl", i), 32'(a_ctl), 32'(tbl[i].ctl));
         chk($sformatf("tbl%0d_stall_cycles", i), 32'(a_sc), 32'(tbl[i].sc));
         chk($sformatf("tbl%0d_flush_count", i), 32'(a_fc), 32'(tbl[i].fc));
      end

      // ---------------- timeout on dut_a (MAX_WAIT=4) ----------------
      cyc(1, 0, 0, 0);
      for (int j = 0; j < 6; j++) begin
         cyc(0, 0, 0, (j < 4) ? 1'b1 : 1'b0);
         chk($sformatf("timeout_err_%0d", j), 32'(a_err), (j >= 4) ? 32'd1 : 32'd0);
         chk($sformatf("timeout_ctl_%0d", j), 32'(a_ctl),
             (j >= 4) ? 32'b000001 : 32'b000000);
      end
      cyc(0, 1, 1, 0);
      chk("timeout_ctl_ignores_inputs", 32'(a_ctl), 32'b000001);
      chk("timeout_stall_hold", 32'(a_sc), 32'd4);
      chk("timeout_flush_hold", 32'(a_fc), 32'd0);
      cyc(1, 0, 0, 0);
      chk("timeout_rst_err", 32'(a_err), 32'd0);
      cyc(0, 0, 0, 0);
      chk("timeout_rst_run", 32'(a_ctl), 32'b110100);

      // ---------------- saturation and no-timeout on dut_b ----------------
      cyc(1, 0, 0, 0);
      for (int j = 0; j < 7; j++) begin
         cyc(0, 1, 0, 0);
         chk($sformatf("sat_stall_%0d", j), 32'(b_sc), (j < 3) ? 32'(j) : 32'd3);
         chk($sformatf("sat_ctl_%0d", j), 32'(b_ctl), 32'b000110);
      end
      cyc(1, 0, 0, 0);
      for (int j = 0; j < 20; j++) cyc(0, 0, 0, 1);
      chk("nolimit_err", 32'(b_err), 32'd0);
      chk("nolimit_ctl", 32'(b_ctl), 32'b000000);
      chk("nolimit_stall_sat", 32'(b_sc), 32'd3);
      cyc(0, 0, 0, 0);
      chk("nolimit_release", 32'(b_ctl), 32'b110100);

      // ---------------- random stimulus vs. model ----------------
      cyc(1, 0, 0, 0);
      begin
         logic b_prev;
         b_prev = 1'b0;
         for (int n = 0; n < 800; n++) begin
            logic r, s, f, b;
            r = ($urandom_range(0, 49) == 0);
            b = b_prev ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            s = ($urandom_range(0, 2) == 0);
            f = ($urandom_range(0, 3) == 0);
            b_prev = b;
            cyc(r, s, f, b);
            chk($sformatf("rnd%0d_a_ctl", n), 32'(a_ctl), 32'(m_ctl(0)));
            chk($sformatf("rnd%0d_a_sc", n),  32'(a_sc),  32'(m_sc[0]));
            chk($sformatf("rnd%0d_a_fc", n),  32'(a_fc),  32'(m_fc[0]));
            chk($sformatf("rnd%0d_b_ctl", n), 32'(b_ctl), 32'(m_ctl(1)));
            chk($sformatf("rnd%0d_b_sc", n),  32'(b_sc),  32'(m_sc[1]));
            chk($sformatf("rnd%0d_b_fc", n),  32'(b_fc),  32'(m_fc[1]));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
